// File: rtl/idct_row_mul.sv
// IDCT row multiply stage: gathers eight coefficients, applies the fixed-point
// rotation constants and registers operands s0..s11. Optional macro: IDCT_ROW_AC_ZERO_EN.
module idct_row_mul #(
   parameter int IN_W = 16,
   parameter int FRAC = 12,
   parameter int KC2  = 3784,
   parameter int KC4  = 2896,
   parameter int KC6  = 1567
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic signed [IN_W-1:0] in_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic signed [31:0]     s0,
   output logic signed [31:0]     s1,
   output logic signed [31:0]     s2,
   output logic signed [31:0]     s3,
   output logic signed [31:0]     s4,
   output logic signed [31:0]     s5,
   output logic signed [31:0]     s6,
   output logic signed [31:0]     s7,
   output logic signed [31:0]     s8,
   output logic signed [31:0]     s9,
   output logic signed [31:0]     s10,
   output logic signed [31:0]     s11
`ifdef IDCT_ROW_AC_ZERO_EN
   ,
   output logic                   out_ac_zero
`endif
);

   localparam int PW    = IN_W + 17;
   localparam int RND_I = 1 << (FRAC - 1);

   localparam logic signed [15:0] K2 = 16'(KC2);
   localparam logic signed [15:0] K4 = 16'(KC4);
   localparam logic signed [15:0] K6 = 16'(KC6);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   state_t                 state;
   state_t                 state_nxt;
   logic [2:0]             cnt;
   logic signed [IN_W-1:0] row_buf [8];
   logic                   accept;
   logic                   load;
   logic signed [31:0]     prod [12];
   logic signed [IN_W:0]   sum17;
   logic signed [IN_W:0]   sum35;

   // Coefficient sign-extended by one bit so pair sums cannot overflow.
   function automatic logic signed [IN_W:0] ext1(input logic signed [IN_W-1:0] x);
      return {x[IN_W-1], x};
   endfunction

   function automatic logic signed [31:0] sx32(input logic signed [IN_W-1:0] x);
      return 32'(x);
   endfunction

   // Round-half-up fixed-point multiply: (a*k + half) >>> FRAC.
   function automatic logic signed [31:0] mul_round(input logic signed [IN_W:0] a,
                                                    input logic signed [15:0]  k);
      logic signed [PW-1:0] p;
      logic signed [PW-1:0] sh;
      p  = PW'(a) * PW'(k);
      p  = p + PW'(RND_I);
      sh = p >>> FRAC;
      return 32'(sh);
   endfunction

   assign accept = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= FILL;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      load      = 1'b0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && (cnt == 3'd7)) begin
               state_nxt = HOLD;
            end
         end
         HOLD: begin
            if (!out_valid || out_ready) begin
               load      = 1'b1;
               state_nxt = FILL;
            end
         end
         default: state_nxt = FILL;
      endcase
   end

   // Stage 0: row collection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= 3'd0;
         for (int i = 0; i < 8; i++) begin
            row_buf[i] <= '0;
         end
      end else if (accept) begin
         row_buf[cnt] <= in_data;
         cnt          <= (cnt == 3'd7) ? 3'd0 : cnt + 3'd1;
      end
   end

   always_comb begin
      sum17    = ext1(row_buf[1]) + ext1(row_buf[7]);
      sum35    = ext1(row_buf[3]) + ext1(row_buf[5]);
      prod[0]  = sx32(row_buf[0]);
      prod[1]  = mul_round(ext1(row_buf[2]), K2);
      prod[2]  = mul_round(ext1(row_buf[6]), K6);
      prod[3]  = sx32(row_buf[4]);
      prod[4]  = sx32(row_buf[1]);
      prod[5]  = sx32(row_buf[7]);
      prod[6]  = sx32(row_buf[5]);
      prod[7]  = sx32(row_buf[3]);
      prod[8]  = mul_round(sum17, K4);
      prod[9]  = mul_round(sum35, K4);
      prod[10] = mul_round(ext1(row_buf[2]), K6);
      prod[11] = mul_round(ext1(row_buf[6]), K2);
   end

   // Stage 1: output operand registers; a load in the same cycle as a drain keeps out_valid high
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         s0  <= '0;
         s1  <= '0;
         s2  <= '0;
         s3  <= '0;
         s4  <= '0;
         s5  <= '0;
         s6  <= '0;
         s7  <= '0;
         s8  <= '0;
         s9  <= '0;
         s10 <= '0;
         s11 <= '0;
      end else begin
         if (load) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
         if (load) begin
            s0  <= prod[0];
            s1  <= prod[1];
            s2  <= prod[2];
            s3  <= prod[3];
            s4  <= prod[4];
            s5  <= prod[5];
            s6  <= prod[6];
            s7  <= prod[7];
            s8  <= prod[8];
            s9  <= prod[9];
            s10 <= prod[10];
            s11 <= prod[11];
         end
      end
   end

`ifdef IDCT_ROW_AC_ZERO_EN
   logic ac_zero;

   always_comb begin
      ac_zero = 1'b1;
      for (int i = 1; i < 8; i++) begin
         if (row_buf[i] != '0) begin
            ac_zero = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_ac_zero <= 1'b0;
      end else if (load) begin
         out_ac_zero <= ac_zero;
      end
   end
`endif

endmodule

// File: tb/tb_idct_row_mul.sv
// Scoreboard bench for idct_row_mul: directed rows, back-pressure, input gaps and mid-row reset.
module tb_idct_row_mul;

   localparam int KC2 = 3784;
   localparam int KC4 = 2896;
   localparam int KC6 = 1567;

   logic               clk;
   logic               rst_n;
   logic               in_valid;
   logic               in_ready;
   logic signed [15:0] in_data;
   logic               out_valid;
   logic               out_ready;
   logic signed [31:0] s0, s1, s2, s3, s4, s5, s6, s7, s8, s9, s10, s11;
`ifdef IDCT_ROW_AC_ZERO_EN
   logic               out_ac_zero;
`endif

   idct_row_mul dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s0        (s0),
      .s1        (s1),
      .s2        (s2),
      .s3        (s3),
      .s4        (s4),
      .s5        (s5),
      .s6        (s6),
      .s7        (s7),
      .s8        (s8),
      .s9        (s9),
      .s10       (s10),
      .s11       (s11)
`ifdef IDCT_ROW_AC_ZERO_EN
      ,
      .out_ac_zero (out_ac_zero)
`endif
   );

   typedef struct packed {
      logic [11:0][31:0] s;
      logic              az;
   } exp_t;

   exp_t               sbq [$];
   exp_t               mon_e;
   int                 checks = 0;
   int                 errors = 0;
   int                 nrow   = 0;
   int                 ev [12];
   logic signed [15:0] rowv [8];
   logic [11:0][31:0]  cur;
   logic [11:0][31:0]  prev_s;
   logic               prev_v;
   logic               prev_r;
   int                 a0;

   assign cur = {s11, s10, s9, s8, s7, s6, s5, s4, s3, s2, s1, s0};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
                tag, $signed(got), got, $signed(exp), exp);
      end
   endtask

   function automatic longint mr(input longint a, input longint k);
      return (a * k + 2048) >>> 12;
   endfunction

   task automatic model_ev();
      ev[0]  = int'(rowv[0]);
      ev[1]  = int'(mr(longint'(rowv[2]), KC2));
      ev[2]  = int'(mr(longint'(rowv[6]), KC6));
      ev[3]  = int'(rowv[4]);
      ev[4]  = int'(rowv[1]);
      ev[5]  = int'(rowv[7]);
      ev[6]  = int'(rowv[5]);
      ev[7]  = int'(rowv[3]);
      ev[8]  = int'(mr(longint'(rowv[1]) + longint'(rowv[7]), KC4));
      ev[9]  = int'(mr(longint'(rowv[3]) + longint'(rowv[5]), KC4));
      ev[10] = int'(mr(longint'(rowv[2]), KC6));
      ev[11] = int'(mr(longint'(rowv[6]), KC2));
   endtask

   task automatic push_ev();
      exp_t e;
      e.az = 1'b1;
      for (int k = 0; k < 12; k++) e.s[k] = ev[k];
      for (int i = 1; i < 8; i++) if (rowv[i] != 16'sd0) e.az = 1'b0;
      sbq.push_back(e);
   endtask

   task automatic rand_row();
      for (int i = 0; i < 8; i++) rowv[i] = 16'($urandom_range(0, 65535));
   endtask

   // Drives rowv[0..n-1]; returns just after the edge accepting the last beat.
   task automatic send_row(input int n, input bit gaps);
      int   g;
      int   cyc;
      logic acc;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            g = $urandom_range(0, 3);
            in_valid = 1'b0;
            repeat (g) begin
               @(posedge clk);
               #1;
            end
         end
         in_valid = 1'b1;
         in_data  = rowv[i];
         acc = 1'b0;
         cyc = 0;
         while (!acc && cyc < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            cyc++;
         end
         if (!acc) chk("accept_timeout", 32'(acc), 1);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while ((sbq.size() != 0 || out_valid) && c < 300) begin
         @(negedge clk);
         c++;
      end
      chk("drain_in_time", 32'(c < 300), 1);
      @(posedge clk);
      #1;
   endtask

   // Output monitor: pops the scoreboard on every delivered result.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         chk("sb_nonempty", 32'(sbq.size() > 0), 1);
         if (sbq.size() > 0) begin
            mon_e = sbq.pop_front();
            nrow++;
            for (int k = 0; k < 12; k++)
               chk($sformatf("row%0d_s%0d", nrow, k), cur[k], mon_e.s[k]);
`ifdef IDCT_ROW_AC_ZERO_EN
            chk($sformatf("row%0d_ac_zero", nrow), 32'(out_ac_zero), 32'(mon_e.az));
`endif
         end
      end
   end

   // Held results must stay valid and unchanged while back-pressured.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_v <= 1'b0;
         prev_r <= 1'b0;
         prev_s <= '0;
      end else begin
         if (prev_v && !prev_r) begin
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_stable", 32'(cur === prev_s), 1);
         end
         prev_v <= out_valid;
         prev_r <= out_ready;
         prev_s <= cur;
      end
   end

   initial begin
      rst_n     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #3 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(in_ready), 1);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_s0", s0, 0);
      chk("rst_s8", s8, 0);
      chk("rst_s11", s11, 0);
`ifdef IDCT_ROW_AC_ZERO_EN
      chk("rst_ac_zero", 32'(out_ac_zero), 0);
`endif
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // DC-only row and latency
      rowv = '{16'sd100, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0, 16'sd0};
      ev   = '{100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      push_ev();
      send_row(8, 1'b0);
      @(negedge clk);
      chk("hold_cycle_out_valid", 32'(out_valid), 0);
      chk("hold_cycle_in_ready", 32'(in_ready), 0);
      @(negedge clk);
      chk("latency_out_valid", 32'(out_valid), 1);
      @(negedge clk);
      chk("single_pulse_out_valid", 32'(out_valid), 0);
      wait_drain();

      // Mixed-sign row
      rowv = '{16'sd0, 16'sd1000, 16'sd2000, 16'sd300, 16'sd0, 16'sd500, -16'sd2000, 16'sd700};
      ev   = '{0, 1848, -765, 0, 1000, 700, 500, 300, 1202, 566, 765, -1848};
      push_ev();
      send_row(8, 1'b0);
      wait_drain();

      // Full-scale negative row
      for (int i = 0; i < 8; i++) rowv[i] = -16'sd32768;
      ev = '{-32768, -30272, -12536, -32768, -32768, -32768, -32768, -32768,
             -46336, -46336, -12536, -30272};
      push_ev();
      send_row(8, 1'b0);
      wait_drain();

      // Reset after a partial row
      rand_row();
      send_row(5, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      chk("midrow_rst_out_valid", 32'(out_valid), 0);
      chk("midrow_rst_in_ready", 32'(in_ready), 1);
      chk("midrow_rst_s0", s0, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      rand_row();
      model_ev();
      push_ev();
      send_row(8, 1'b0);
      wait_drain();

      // Two rows under back-pressure
      out_ready = 1'b0;
      rand_row();
      a0 = int'(rowv[0]);
      model_ev();
      push_ev();
      send_row(8, 1'b0);
      rand_row();
      model_ev();
      push_ev();
      send_row(8, 1'b0);
      repeat (20) begin
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      chk("b2b_in_ready", 32'(in_ready), 0);
      chk("b2b_out_valid", 32'(out_valid), 1);
      chk("b2b_row1_s0", s0, a0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      wait_drain();

      // Gapped input streams
      rowv = '{16'sd0, 16'sd1000, 16'sd2000, 16'sd300, 16'sd0, 16'sd500, -16'sd2000, 16'sd700};
      ev   = '{0, 1848, -765, 0, 1000, 700, 500, 300, 1202, 566, 765, -1848};
      push_ev();
      send_row(8, 1'b1);
      wait_drain();
      for (int r = 0; r < 3; r++) begin
         rand_row();
         model_ev();
         push_ev();
         send_row(8, 1'b1);
      end
      wait_drain();

      chk("sb_leftover", 32'(sbq.size()), 0);
      chk("rows_delivered", 32'(nrow), 10);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
